// File: rtl/systolic_gemm_stream.sv
// Output-stationary NxN systolic GEMM core. Each beat carries one K-slice (column
// of A, row of B), is skewed internally, and results stream out row by row.
module systolic_gemm_stream #(
    parameter int N      = 4,
    parameter int DW     = 32,
    parameter int AW     = 64,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic            acc_en,
    input  logic [N*DW-1:0] a_west_vec,
    input  logic [N*DW-1:0] b_north_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*AW-1:0] out_row,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0] out_row_idx,
    output logic            out_last,
    output logic            done,
    output logic            busy
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam int CW = $clog2(2 * N) + 1;

    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_OUTPUT} state_t;

    state_t          state_q, state_d;
    logic            first_q, first_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            beat;
    logic            clr_inj;

    function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [AW-1:0] ax;
        logic [AW-1:0] bx;
        if (SIGNED != 0) begin
            ax = {{(AW-DW){a[DW-1]}}, a};
            bx = {{(AW-DW){b[DW-1]}}, b};
        end else begin
            ax = {{(AW-DW){1'b0}}, a};
            bx = {{(AW-DW){1'b0}}, b};
        end
        return ax * bx;
    endfunction

    assign beat    = in_valid && (state_q == S_LOAD);
    // The "start fresh" marker rides with the A operand so every PE clears on its own first product.
    assign clr_inj = beat && first_q && !acc_en;

    logic [DW-1:0] a_edge   [N];
    logic [DW-1:0] b_edge   [N];
    logic          clr_edge [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_inj;
        logic [DW-1:0] b_inj;
        assign a_inj = beat ? a_west_vec[i*DW +: DW]  : '0;
        assign b_inj = beat ? b_north_vec[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_edge[0]   = a_inj;
            assign b_edge[0]   = b_inj;
            assign clr_edge[0] = clr_inj;
        end else begin : g_dly
            logic [DW-1:0] a_sr_q   [i];
            logic [DW-1:0] b_sr_q   [i];
            logic          clr_sr_q [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr_q[d]   <= '0;
                        b_sr_q[d]   <= '0;
                        clr_sr_q[d] <= 1'b0;
                    end
                end else begin
                    a_sr_q[0]   <= a_inj;
                    b_sr_q[0]   <= b_inj;
                    clr_sr_q[0] <= clr_inj;
                    for (int d = 1; d < i; d++) begin
                        a_sr_q[d]   <= a_sr_q[d-1];
                        b_sr_q[d]   <= b_sr_q[d-1];
                        clr_sr_q[d] <= clr_sr_q[d-1];
                    end
                end
            end
            assign a_edge[i]   = a_sr_q[i-1];
            assign b_edge[i]   = b_sr_q[i-1];
            assign clr_edge[i] = clr_sr_q[i-1];
        end
    end

    logic [DW-1:0] a_w   [N][N-1];
    logic          clr_w [N][N-1];
    logic [DW-1:0] b_w   [N-1][N];
    logic [AW-1:0] acc_w [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            logic [DW-1:0] a_in;
            logic [DW-1:0] b_in;
            logic          clr_in;
            logic [AW-1:0] prod;
            logic [AW-1:0] acc_q;
            if (j == 0) begin : g_a_edge
                assign a_in   = a_edge[i];
                assign clr_in = clr_edge[i];
            end else begin : g_a_mesh
                assign a_in   = a_w[i][j-1];
                assign clr_in = clr_w[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in = b_edge[j];
            end else begin : g_b_mesh
                assign b_in = b_w[i-1][j];
            end
            assign prod = mul_ext(a_in, b_in);
            always_ff @(posedge clk) begin
                if (rst)         acc_q <= '0;
                else if (clr_in) acc_q <= prod;
                else             acc_q <= acc_q + prod;
            end
            assign acc_w[i][j] = acc_q;
            if (j < N - 1) begin : g_fwd_a
                logic [DW-1:0] a_q;
                logic          clr_q;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q   <= '0;
                        clr_q <= 1'b0;
                    end else begin
                        a_q   <= a_in;
                        clr_q <= clr_in;
                    end
                end
                assign a_w[i][j]   = a_q;
                assign clr_w[i][j] = clr_q;
            end
            if (i < N - 1) begin : g_fwd_b
                logic [DW-1:0] b_q;
                always_ff @(posedge clk) begin
                    if (rst) b_q <= '0;
                    else     b_q <= b_in;
                end
                assign b_w[i][j] = b_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            first_q <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_LOAD: begin
                if (beat) begin
                    first_d = 1'b0;
                    if (first_q) done_d = 1'b0;
                    if (in_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                // 2N cycles covers the 2N-2 skew/mesh latency to the far corner PE.
                if (cnt_q == CW'(2 * N - 1)) begin
                    state_d = S_OUTPUT;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (idx_q == IW'(N - 1)) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        out_row = '0;
        if (state_q == S_OUTPUT) begin
            for (int j = 0; j < N; j++) out_row[j*AW +: AW] = acc_w[idx_q][j];
        end
    end

    assign in_ready    = (state_q == S_LOAD);
    assign out_valid   = (state_q == S_OUTPUT);
    assign out_row_idx = idx_q;
    assign out_last    = (state_q == S_OUTPUT) && (idx_q == IW'(N - 1));
    assign done        = done_q;
    assign busy        = (state_q != S_LOAD) || !first_q;
endmodule
